// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit: access-size decode,
// FSM state encoding and byte-lane mask helpers.
package mem_stage_pkg;

  typedef enum logic [1:0] {SzB = 2'd0, SzH = 2'd1, SzW = 2'd2, SzD = 2'd3} size_e;

  typedef enum logic [1:0] {StIdle, StReq, StWaitRsp} state_e;

  // funct3[2] selects zero-extension on loads
  localparam int unsigned Funct3UnsignedBit = 2;

  // Doubleword only exists on a 64-bit datapath; otherwise fall back to word.
  function automatic size_e decode_size(input logic [2:0] funct3, input logic wide);
    size_e sz;
    unique case (funct3[1:0])
      2'b00:   sz = SzB;
      2'b01:   sz = SzH;
      2'b10:   sz = SzW;
      default: sz = wide ? SzD : SzW;
    endcase
    return sz;
  endfunction

  function automatic logic [7:0] size_be_mask(input size_e sz);
    logic [7:0] m;
    unique case (sz)
      SzB:     m = 8'h01;
      SzH:     m = 8'h03;
      SzW:     m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_align_mask(input size_e sz);
    logic [2:0] m;
    unique case (sz)
      SzB:     m = 3'd0;
      SzH:     m = 3'd1;
      SzW:     m = 3'd3;
      default: m = 3'd7;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory channel: valid/ready request plus response-valid load return.
interface mem_stage_lsu_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned BE_W = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane logic: store replication/byte enables and load lane
// extraction with sign/zero extension (FP word loads are NaN-boxed).
module mem_stage_lsu_align import mem_stage_pkg::*; #(
  parameter  int unsigned XLEN  = 32,
  localparam int unsigned BE_W  = XLEN / 8,
  localparam int unsigned OFF_W = $clog2(BE_W)
) (
  input  size_e            size_i,
  input  logic             unsigned_i,
  input  logic             is_fp_i,
  input  logic [OFF_W-1:0] lane_i,
  input  logic [XLEN-1:0]  store_data_i,
  input  logic [XLEN-1:0]  rdata_i,
  output logic [BE_W-1:0]  be_o,
  output logic [XLEN-1:0]  wdata_o,
  output logic [XLEN-1:0]  load_data_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted     = rdata_i >> {lane_i, 3'b000};
    be_o        = BE_W'(size_be_mask(size_i)) << lane_i;
    wdata_o     = store_data_i;
    load_data_o = shifted;
    unique case (size_i)
      SzB: begin
        wdata_o     = {(XLEN / 8){store_data_i[7:0]}};
        load_data_o = XLEN'(shifted[7:0]) |
                      ((shifted[7] & ~unsigned_i) ? ~XLEN'(8'hFF) : '0);
      end
      SzH: begin
        wdata_o     = {(XLEN / 16){store_data_i[15:0]}};
        load_data_o = XLEN'(shifted[15:0]) |
                      ((shifted[15] & ~unsigned_i) ? ~XLEN'(16'hFFFF) : '0);
      end
      SzW: begin
        wdata_o     = {(XLEN / 32){store_data_i[31:0]}};
        // FLW fills the upper half with ones; a no-op on a 32-bit datapath
        load_data_o = XLEN'(shifted[31:0]) |
                      ((is_fp_i | (shifted[31] & ~unsigned_i)) ? ~XLEN'(32'hFFFF_FFFF) : '0);
      end
      default: begin
        wdata_o     = store_data_i;
        load_data_o = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: issues loads/stores to dmem, stalls while an access is
// outstanding and registers the WB slot. Optional: MEM_MISALIGN_CHECK_EN.
module mem_stage_lsu import mem_stage_pkg::*; #(
  parameter  int unsigned XLEN   = 32,
  parameter  int unsigned ADDR_W = 32,
  localparam int unsigned BE_W   = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_is_fp,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic            ex_wb_enable,
  input  logic [4:0]      ex_rd,
  output logic            mem_stall,
  mem_stage_lsu_if.master dmem,
  output logic            wb_valid,
  output logic            wb_enable,
  output logic            wb_fp_enable,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_ld,
  output logic            misalign_err
);

  localparam int unsigned OFF_W = $clog2(BE_W);

  state_e           state_q, state_d;
  size_e            sz;
  logic [OFF_W-1:0] addr_off, align_m, lane;
  logic             legal_mem, misalign, mem_go, is_store, int_we, fp_we, req_valid;
  logic [BE_W-1:0]  be;
  logic [XLEN-1:0]  wdata, load_data;

  logic            wb_valid_q, wb_valid_d, wb_enable_q, wb_enable_d;
  logic            wb_fp_enable_q, wb_fp_enable_d, wb_ld_q, wb_ld_d;
  logic            misalign_err_q, misalign_err_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  assign sz        = decode_size(ex_funct3, XLEN == 64);
  assign addr_off  = ex_alu_out[OFF_W-1:0];
  assign align_m   = OFF_W'(size_align_mask(sz));
  assign lane      = addr_off & ~align_m;
  // read and write together is illegal and falls through as a non-writing slot
  assign legal_mem = ex_valid & (ex_mem_read ^ ex_mem_write);
  assign is_store  = ex_mem_write;
  assign int_we    = ex_wb_enable & ~ex_is_fp & (ex_rd != 5'd0);
  assign fp_we     = ex_wb_enable & ex_is_fp;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = legal_mem & (|(addr_off & align_m));
`else
  assign misalign = 1'b0;
`endif

  assign mem_go = legal_mem & ~misalign;

  mem_stage_lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .size_i      (sz),
    .unsigned_i  (ex_funct3[Funct3UnsignedBit]),
    .is_fp_i     (ex_is_fp),
    .lane_i      (lane),
    .store_data_i(ex_store_data),
    .rdata_i     (dmem.rsp_rdata),
    .be_o        (be),
    .wdata_o     (wdata),
    .load_data_o (load_data)
  );

  // Request fields come straight from ex_*, which upstream holds while stalled.
  assign dmem.req_valid = req_valid;
  assign dmem.req_we    = is_store;
  assign dmem.req_addr  = {ex_alu_out[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign dmem.req_wdata = wdata;
  assign dmem.req_be    = be;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (mem_go) begin
          if (dmem.req_ready) state_d = is_store ? StIdle : StWaitRsp;
          else                state_d = StReq;
        end
      end
      StReq:     if (dmem.req_ready) state_d = is_store ? StIdle : StWaitRsp;
      StWaitRsp: if (dmem.rsp_valid) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    req_valid      = 1'b0;
    mem_stall      = 1'b0;
    wb_valid_d     = 1'b0;
    wb_enable_d    = 1'b0;
    wb_fp_enable_d = 1'b0;
    wb_ld_d        = 1'b0;
    misalign_err_d = 1'b0;
    wb_rd_d        = ex_rd;
    wb_data_d      = ex_alu_out;
    unique case (state_q)
      StIdle: begin
        if (mem_go) begin
          req_valid  = 1'b1;
          mem_stall  = ~(is_store & dmem.req_ready);
          wb_valid_d = is_store & dmem.req_ready;
        end else begin
          wb_valid_d     = ex_valid;
          wb_enable_d    = ex_valid & int_we & ~(ex_mem_read | ex_mem_write);
          wb_fp_enable_d = ex_valid & fp_we & ~(ex_mem_read | ex_mem_write);
          misalign_err_d = misalign;
        end
      end
      StReq: begin
        req_valid  = 1'b1;
        mem_stall  = ~(is_store & dmem.req_ready);
        wb_valid_d = is_store & dmem.req_ready;
      end
      StWaitRsp: begin
        mem_stall = ~dmem.rsp_valid;
        if (dmem.rsp_valid) begin
          wb_valid_d     = 1'b1;
          wb_enable_d    = int_we;
          wb_fp_enable_d = fp_we;
          wb_ld_d        = 1'b1;
          wb_data_d      = load_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q     <= 1'b0;
      wb_enable_q    <= 1'b0;
      wb_fp_enable_q <= 1'b0;
      wb_ld_q        <= 1'b0;
      misalign_err_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= '0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_enable_q    <= wb_enable_d;
      wb_fp_enable_q <= wb_fp_enable_d;
      wb_ld_q        <= wb_ld_d;
      misalign_err_q <= misalign_err_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_enable    = wb_enable_q;
  assign wb_fp_enable = wb_fp_enable_q;
  assign wb_ld        = wb_ld_q;
  assign misalign_err = misalign_err_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu (XLEN=32): loads, stores, FP routing, reset
// mid-access and misaligned access with or without MEM_MISALIGN_CHECK_EN.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_is_fp, ex_wb_enable;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_out, ex_store_data;
  logic [4:0]  ex_rd;
  logic        mem_stall, wb_valid, wb_enable, wb_fp_enable, wb_ld, misalign_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_err = 0;

  int          cap_stalls;
  logic        cap_held;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  mem_stage_lsu_if #(.XLEN(32), .ADDR_W(32)) dmem_bus ();

  mem_stage_lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_funct3    (ex_funct3),
    .ex_is_fp     (ex_is_fp),
    .ex_alu_out   (ex_alu_out),
    .ex_store_data(ex_store_data),
    .ex_wb_enable (ex_wb_enable),
    .ex_rd        (ex_rd),
    .mem_stall    (mem_stall),
    .dmem         (dmem_bus),
    .wb_valid     (wb_valid),
    .wb_enable    (wb_enable),
    .wb_fp_enable (wb_fp_enable),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_ld        (wb_ld),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic ld, input logic st, input logic fp,
                          input logic wbe, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [4:0] rd);
    ex_valid      = v;
    ex_mem_read   = ld;
    ex_mem_write  = st;
    ex_is_fp      = fp;
    ex_wb_enable  = wbe;
    ex_funct3     = f3;
    ex_alu_out    = addr;
    ex_store_data = sd;
    ex_rd         = rd;
  endtask

  // Accepted at once; response arrives in the third cycle after the accepting one.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic fp,
                         input logic [4:0] rd, input logic [31:0] rdata);
    drive_ex(1'b1, 1'b1, 1'b0, fp, 1'b1, f3, addr, 32'h0, rd);
    dmem_bus.req_ready = 1'b1;
    #1;
    cap_addr   = dmem_bus.req_addr;
    cap_held   = dmem_bus.req_valid && !dmem_bus.req_we;
    cap_stalls = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 3) begin
        dmem_bus.rsp_valid = 1'b1;
        dmem_bus.rsp_rdata = rdata;
        #1;
      end
      if (c == 1) check_eq("load_bubble_wb_valid", wb_valid, 0);
      if (!mem_stall) break;
      cap_stalls++;
      tick();
    end
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    dmem_bus.rsp_valid = 1'b0;
    dmem_bus.req_ready = 1'b0;
  endtask

  // Ready held low for `hold` cycles; request fields must stay stable meanwhile.
  task automatic do_store(input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] sd, input int hold);
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, f3, addr, sd, 5'd0);
    dmem_bus.req_ready = 1'b0;
    #1;
    cap_addr   = dmem_bus.req_addr;
    cap_be     = dmem_bus.req_be;
    cap_wdata  = dmem_bus.req_wdata;
    cap_held   = 1'b1;
    cap_stalls = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == hold) begin
        dmem_bus.req_ready = 1'b1;
        #1;
      end
      cap_held &= dmem_bus.req_valid && dmem_bus.req_we && dmem_bus.req_addr == cap_addr &&
                  dmem_bus.req_be == cap_be && dmem_bus.req_wdata == cap_wdata;
      if (!mem_stall) break;
      cap_stalls++;
      tick();
    end
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    dmem_bus.req_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    dmem_bus.req_ready = 1'b0;
    dmem_bus.rsp_valid = 1'b0;
    dmem_bus.rsp_rdata = 32'h0;
    tick();
    tick();
    check_eq("rst_wb_valid", wb_valid, 0);
    check_eq("rst_wb_enable", wb_enable, 0);
    check_eq("rst_wb_data", wb_data, 0);
    check_eq("rst_misalign", misalign_err, 0);
    check_eq("rst_req_valid", dmem_bus.req_valid, 0);
    rst = 1'b0;

    // ALU pass-through, one-cycle latency
    drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h55, 32'h0, 5'd3);
    #1;
    check_eq("alu_stall", mem_stall, 0);
    tick();
    check_eq("alu_wb_valid", wb_valid, 1);
    check_eq("alu_wb_enable", wb_enable, 1);
    check_eq("alu_wb_data", wb_data, 32'h55);
    check_eq("alu_wb_rd", wb_rd, 3);

    drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h66, 32'h0, 5'd0);
    tick();
    check_eq("alu_rd0_wb_enable", wb_enable, 0);
    check_eq("alu_rd0_wb_data", wb_data, 32'h66);

    do_load(32'h10, 3'b010, 1'b0, 5'd4, 32'hDEAD_BEEF);
    check_eq("lw_req_addr", cap_addr, 32'h10);
    check_eq("lw_req_seen", cap_held, 1);
    check_eq("lw_stalls", cap_stalls, 3);
    check_eq("lw_wb_data", wb_data, 32'hDEAD_BEEF);
    check_eq("lw_wb_enable", wb_enable, 1);
    check_eq("lw_wb_ld", wb_ld, 1);
    check_eq("lw_wb_rd", wb_rd, 4);

    do_load(32'h13, 3'b000, 1'b0, 5'd4, 32'h80FF_FFFF);
    check_eq("lb_wb_data", wb_data, 32'hFFFF_FF80);
    do_load(32'h13, 3'b100, 1'b0, 5'd4, 32'h80FF_FFFF);
    check_eq("lbu_wb_data", wb_data, 32'h0000_0080);
    do_load(32'h12, 3'b001, 1'b0, 5'd4, 32'h8001_1234);
    check_eq("lh_wb_data", wb_data, 32'hFFFF_8001);
    do_load(32'h12, 3'b101, 1'b0, 5'd4, 32'h8001_1234);
    check_eq("lhu_wb_data", wb_data, 32'h0000_8001);

    do_load(32'h20, 3'b010, 1'b1, 5'd5, 32'h3F80_0000);
    check_eq("flw_wb_fp_enable", wb_fp_enable, 1);
    check_eq("flw_wb_enable", wb_enable, 0);
    check_eq("flw_wb_data", wb_data, 32'h3F80_0000);

    do_store(32'h22, 3'b001, 32'h1234_ABCD, 2);
    check_eq("sh_be", cap_be, 4'b1100);
    check_eq("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    check_eq("sh_addr", cap_addr, 32'h20);
    check_eq("sh_held", cap_held, 1);
    check_eq("sh_stalls", cap_stalls, 2);
    check_eq("sh_wb_valid", wb_valid, 1);
    check_eq("sh_wb_enable", wb_enable, 0);

    do_store(32'h21, 3'b000, 32'h0000_00EF, 0);
    check_eq("sb_be", cap_be, 4'b0010);
    check_eq("sb_wdata", cap_wdata, 32'hEFEF_EFEF);
    check_eq("sb_stalls", cap_stalls, 0);

    do_store(32'h30, 3'b010, 32'h1122_3344, 1);
    check_eq("sw_be", cap_be, 4'b1111);
    check_eq("sw_wdata", cap_wdata, 32'h1122_3344);
    check_eq("sw_stalls", cap_stalls, 1);

    // Reset while waiting for a response, then a late response must be ignored
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 5'd6);
    dmem_bus.req_ready = 1'b1;
    tick();
    dmem_bus.req_ready = 1'b0;
    check_eq("wait_stall", mem_stall, 1);
    rst = 1'b1;
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 5'd0);
    check_eq("midrst_wb_valid", wb_valid, 0);
    check_eq("midrst_wb_data", wb_data, 0);
    rst = 1'b0;
    dmem_bus.rsp_valid = 1'b1;
    dmem_bus.rsp_rdata = 32'h1234;
    #1;
    check_eq("late_rsp_stall", mem_stall, 0);
    check_eq("late_rsp_req_valid", dmem_bus.req_valid, 0);
    tick();
    dmem_bus.rsp_valid = 1'b0;
    check_eq("late_rsp_wb_data", wb_data, 32'h77);
    check_eq("late_rsp_wb_ld", wb_ld, 0);

    drive_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h99, 32'h0, 5'd7);
    #1;
    check_eq("post_rst_stall", mem_stall, 0);
    tick();
    check_eq("post_rst_wb_data", wb_data, 32'h99);
    check_eq("post_rst_wb_valid", wb_valid, 1);

`ifdef MEM_MISALIGN_CHECK_EN
    drive_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h11, 32'h0, 5'd8);
    dmem_bus.req_ready = 1'b1;
    #1;
    check_eq("mis_req_valid", dmem_bus.req_valid, 0);
    check_eq("mis_stall", mem_stall, 0);
    tick();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    dmem_bus.req_ready = 1'b0;
    check_eq("mis_err", misalign_err, 1);
    check_eq("mis_wb_valid", wb_valid, 1);
    check_eq("mis_wb_enable", wb_enable, 0);
    tick();
    check_eq("mis_err_clear", misalign_err, 0);
`else
    do_load(32'h11, 3'b010, 1'b0, 5'd8, 32'hCAFE_F00D);
    check_eq("mis_req_addr", cap_addr, 32'h10);
    check_eq("mis_wb_data", wb_data, 32'hCAFE_F00D);
    check_eq("mis_err", misalign_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
